// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared payload type and constants for the pipeline stage register
package pipe_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;
  localparam int EXC_W_DEF  = 5;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam int          EXC_NONE       = 0;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
    logic [EXC_W_DEF-1:0]  exc;
    logic                  bd;
  } pipe_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline entry: payload register plus valid bit
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              INST_W     = INST_W_DEF,
  parameter int              EXC_W      = EXC_W_DEF,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(HANDLER_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_bubble_i,
  input  logic              clr_handler_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [EXC_W-1:0]  exc_i,
  input  logic              bd_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [EXC_W-1:0]  exc_o,
  output logic              bd_o
);

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic              bd_q, bd_d;

  // Next entry contents: handler clear beats bubble clear beats load; a bubble is always inst 0
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    if (clr_handler_i) begin
      valid_d = 1'b0;
      pc_d    = HANDLER_PC;
      inst_d  = '0;
      exc_d   = EXC_W'(EXC_NONE);
      bd_d    = 1'b0;
    end else if (clr_bubble_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      inst_d  = '0;
      exc_d   = EXC_W'(EXC_NONE);
      bd_d    = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
      exc_d   = exc_i;
      bd_d    = bd_i;
    end
  end

  // Entry register, reset to an empty all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign exc_o   = exc_q;
  assign bd_o    = bd_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline stage register; two-entry skid buffer when PIPE_SKID_EN is defined
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              INST_W     = INST_W_DEF,
  parameter int              EXC_W      = EXC_W_DEF,
  parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(HANDLER_PC_DEF),
  parameter int              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  input  logic              flush,
  input  logic              req,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              in_xfer, out_xfer;
  logic              ld0, bub0, hdl0;
  logic [PC_W-1:0]   pc0_in;
  logic [INST_W-1:0] inst0_in;
  logic [EXC_W-1:0]  exc0_in;
  logic              bd0_in;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic              v1, v1_d, ld1, bub1, from1, in_ready_q;
  logic [PC_W-1:0]   pc1;
  logic [INST_W-1:0] inst1;
  logic [EXC_W-1:0]  exc1;
  logic              bd1;

  // Entry control: entry 0 is the output slot, entry 1 catches one word while downstream stalls
  always_comb begin
    ld0   = 1'b0;
    bub0  = 1'b0;
    hdl0  = 1'b0;
    ld1   = 1'b0;
    bub1  = 1'b0;
    from1 = 1'b0;
    if (req) begin
      hdl0 = 1'b1;
      bub1 = 1'b1;
    end else if (flush) begin
      bub0 = 1'b1;
      bub1 = 1'b1;
    end else if (out_xfer) begin
      if (v1) begin
        ld0   = 1'b1;
        from1 = 1'b1;
        ld1   = in_xfer;
        bub1  = !in_xfer;
      end else if (in_xfer) begin
        ld0 = 1'b1;
      end else begin
        bub0 = 1'b1;
      end
    end else if (in_xfer) begin
      ld0 = !out_valid;
      ld1 = out_valid;
    end
  end

  assign v1_d     = ld1 || (v1 && !bub1);
  assign pc0_in   = from1 ? pc1   : in_pc;
  assign inst0_in = from1 ? inst1 : in_inst;
  assign exc0_in  = from1 ? exc1  : in_exc;
  assign bd0_in   = from1 ? bd1   : in_bd;

  // Registered ready: accept while the skid entry will be empty next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_ready_q <= 1'b1;
    else      in_ready_q <= !v1_d;
  end

  assign in_ready = in_ready_q;

  pipe_slot #(
    .PC_W(PC_W), .INST_W(INST_W), .EXC_W(EXC_W), .HANDLER_PC(HANDLER_PC)
  ) u_slot1 (
    .clk(clk), .rst(rst),
    .load_i(ld1), .clr_bubble_i(bub1), .clr_handler_i(1'b0),
    .pc_i(in_pc), .inst_i(in_inst), .exc_i(in_exc), .bd_i(in_bd),
    .valid_o(v1), .pc_o(pc1), .inst_o(inst1), .exc_o(exc1), .bd_o(bd1)
  );
`else
  // Single-entry control: a load always wins over draining, since loading replaces the drained word
  always_comb begin
    ld0  = 1'b0;
    bub0 = 1'b0;
    hdl0 = 1'b0;
    if (req)           hdl0 = 1'b1;
    else if (flush)    bub0 = 1'b1;
    else if (in_xfer)  ld0  = 1'b1;
    else if (out_xfer) bub0 = 1'b1;
  end

  assign in_ready = !out_valid || out_ready;
  assign pc0_in   = in_pc;
  assign inst0_in = in_inst;
  assign exc0_in  = in_exc;
  assign bd0_in   = in_bd;
`endif

  pipe_slot #(
    .PC_W(PC_W), .INST_W(INST_W), .EXC_W(EXC_W), .HANDLER_PC(HANDLER_PC)
  ) u_slot0 (
    .clk(clk), .rst(rst),
    .load_i(ld0), .clr_bubble_i(bub0), .clr_handler_i(hdl0),
    .pc_i(pc0_in), .inst_i(inst0_in), .exc_i(exc0_in), .bd_i(bd0_in),
    .valid_o(out_valid), .pc_o(out_pc), .inst_o(out_inst), .exc_o(out_exc), .bd_o(out_bd)
  );

  // Stall counter: counts held-but-not-taken cycles, sticks at all-ones, only reset clears it
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, flush, req;
  logic [31:0] in_pc, in_inst;
  logic [4:0]  in_exc;
  logic        in_bd;

  logic        in_ready, out_valid, out_bd;
  logic [31:0] out_pc, out_inst;
  logic [4:0]  out_exc;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_out_bd;
  logic [31:0] s_out_pc, s_out_inst;
  logic [4:0]  s_out_exc;
  logic [3:0]  s_stall_cnt;

  pipe_stage_reg u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc), .out_bd(out_bd),
    .flush(flush), .req(req), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_inst(s_out_inst), .out_exc(s_out_exc), .out_bd(s_out_bd),
    .flush(flush), .req(req), .stall_cnt(s_stall_cnt)
  );

  int tests = 0;
  int fails = 0;

  pipe_payload_t mq[$];
  pipe_payload_t bub;
  pipe_payload_t exp_p;
  int            cnt16, cnt4;
  bit            chk_en;
  bit            acc;
  int            n_acc;
  logic [31:0]   emitted[$];
  logic [31:0]   pc;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (mq.size() < CAP) || (CAP == 1 && out_ready);
  endfunction

  task automatic model_step();
    pipe_payload_t p;
    bit rdy, ox, ix;
    if (!rst) begin
      mq.delete();
      bub   = '0;
      cnt16 = 0;
      cnt4  = 0;
    end else begin
      rdy = model_ready();
      if (mq.size() > 0 && !out_ready) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (req) begin
        mq.delete();
        bub = '{pc: HANDLER_PC_DEF, inst: '0, exc: '0, bd: 1'b0};
      end else if (flush) begin
        mq.delete();
        bub = '0;
      end else begin
        ox = (mq.size() > 0) && out_ready;
        ix = in_valid && rdy;
        if (ox) void'(mq.pop_front());
        if (ix) begin
          p = '{pc: in_pc, inst: in_inst, exc: in_exc, bd: in_bd};
          mq.push_back(p);
        end
        if (ox && mq.size() == 0) bub = '0;
      end
    end
  endtask

  task automatic cyc(input bit iv, input logic [31:0] p, input bit orr,
                     input bit fl = 1'b0, input bit rq = 1'b0);
    in_valid  = iv;
    in_pc     = p;
    in_inst   = {16'hC0DE, p[15:0]};
    in_exc    = p[6:2];
    in_bd     = p[2];
    out_ready = orr;
    flush     = fl;
    req       = rq;
    #3;
    acc = iv && in_ready;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_p = (mq.size() > 0) ? mq[0] : bub;
        check("out_valid", 80'(out_valid), 80'(mq.size() > 0));
        check("payload", 80'({out_pc, out_inst, out_exc, out_bd}), 80'(exp_p));
        check("in_ready", 80'(in_ready), 80'(model_ready()));
        check("stall_cnt", 80'(stall_cnt), 80'(cnt16));
        check("stall_cnt_w4", 80'(s_stall_cnt), 80'(cnt4));
        if (out_valid && out_ready) emitted.push_back(out_pc);
      end
    end
  end

  logic [31:0] exp_stall[2];
  logic [3:0]  rdy_pat[4];

  initial begin
    exp_stall = '{32'h3000, 32'h3004};
    rdy_pat   = '{4'b1100, 4'b1011, 4'b1000, 4'b1110};
    chk_en    = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    in_exc    = '0;
    in_bd     = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    req       = 1'b0;
    mq.delete();
    bub   = '0;
    cnt16 = 0;
    cnt4  = 0;

    repeat (3) cyc(1'b1, 32'h1234, 1'b0);
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_out_pc", 80'(out_pc), 80'(0));
    check("rst_in_ready", 80'(in_ready), 80'(1));
    check("rst_stall_cnt", 80'(stall_cnt), 80'(0));

    rst    = 1'b1;
    chk_en = 1'b1;
    cyc(1'b0, 32'h0, 1'b1);
    check("rel_out_valid", 80'(out_valid), 80'(0));
    check("rel_out_pc", 80'(out_pc), 80'(0));
    check("rel_in_ready", 80'(in_ready), 80'(1));
    check("rel_stall_cnt", 80'(stall_cnt), 80'(0));

    // four-word stream at full throughput
    emitted.delete();
    cyc(1'b1, 32'h3000, 1'b1);
    check("stream_first_valid", 80'(out_valid), 80'(1));
    check("stream_first_pc", 80'(out_pc), 80'(32'h3000));
    check("stream_first_inst", 80'(out_inst), 80'(32'hC0DE_3000));
    cyc(1'b1, 32'h3004, 1'b1);
    cyc(1'b1, 32'h3008, 1'b1);
    cyc(1'b1, 32'h300C, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("stream_count", 80'(emitted.size()), 80'(4));
    for (int i = 0; i < 4 && i < emitted.size(); i++)
      check("stream_order", 80'(emitted[i]), 80'(32'h3000 + 32'(4 * i)));

    // stall with downstream blocked, then drain
    emitted.delete();
    n_acc = 0;
    cyc(1'b1, 32'h3000, 1'b0);
    n_acc += int'(acc);
    cyc(1'b1, 32'h3004, 1'b0);
    n_acc += int'(acc);
    check("stall_in_ready_low", 80'(in_ready), 80'(0));
    check("stall_accepts", 80'(n_acc), 80'(CAP));
    repeat (3) cyc(1'b0, 32'h0, 1'b0);
    check("stall_hold_pc", 80'(out_pc), 80'(32'h3000));
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    check("stall_drain_count", 80'(emitted.size()), 80'(CAP));
    for (int i = 0; i < CAP && i < emitted.size(); i++)
      check("stall_drain_order", 80'(emitted[i]), 80'(exp_stall[i]));
    check("stall_cnt_value", 80'(stall_cnt), 80'(4));

    // flush while full with a new word offered
    emitted.delete();
    cyc(1'b1, 32'h3000, 1'b0);
    cyc(1'b1, 32'h3004, 1'b0);
    cyc(1'b1, 32'h3008, 1'b0, 1'b1, 1'b0);
    check("flush_out_valid", 80'(out_valid), 80'(0));
    check("flush_out_inst", 80'(out_inst), 80'(0));
    check("flush_out_pc", 80'(out_pc), 80'(0));
    check("flush_in_ready", 80'(in_ready), 80'(1));
    check("flush_stall_kept", 80'(stall_cnt), 80'(6));
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("flush_nothing_emitted", 80'(emitted.size()), 80'(0));

    // exception request together with flush and a valid input
    cyc(1'b1, 32'h3010, 1'b1);
    cyc(1'b1, 32'h3014, 1'b1, 1'b1, 1'b1);
    check("req_out_pc", 80'(out_pc), 80'(32'h0000_4180));
    check("req_out_exc", 80'(out_exc), 80'(0));
    check("req_out_valid", 80'(out_valid), 80'(0));
    check("req_out_inst", 80'(out_inst), 80'(0));
    cyc(1'b0, 32'h0, 1'b1);
    check("req_pc_holds", 80'(out_pc), 80'(32'h0000_4180));

    // irregular downstream readiness, upstream holds each word until accepted
    emitted.delete();
    pc    = 32'h3100;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, pc, rdy_pat[i / 4][3 - (i % 4)]);
      if (acc) begin
        pc = pc + 32'd4;
        n_acc++;
      end
    end
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    check("mixed_count", 80'(emitted.size()), 80'(n_acc));
    for (int i = 0; i < emitted.size(); i++)
      check("mixed_order", 80'(emitted[i]), 80'(32'h3100 + 32'(4 * i)));

    // counter saturation from a fresh reset
    chk_en = 1'b0;
    rst    = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);
    rst    = 1'b1;
    chk_en = 1'b1;
    cyc(1'b1, 32'h3200, 1'b0);
    repeat (20) cyc(1'b0, 32'h0, 1'b0);
    check("sat_w4", 80'(s_stall_cnt), 80'(15));
    check("sat_w16", 80'(stall_cnt), 80'(20));
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    check("sat_after_flush_w4", 80'(s_stall_cnt), 80'(15));
    check("sat_after_flush_w16", 80'(stall_cnt), 80'(21));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
